// File: rtl/blockade_input_cond.sv
// Input conditioning for the Blockade core: registered joystick sampling,
// DIP latch from the OSD download stream, a fixed-length coin pulse with
// lockout, and a per-player last-pressed 4-way direction arbiter.
// All core-facing bytes are active low.
module blockade_input_cond #(
  parameter int COIN_HOLD = 1000000,
  parameter int COIN_GAP  = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [7:0]  in0,
  output logic [7:0]  in1,
  output logic [7:0]  in2,
  output logic        coin_busy
);

  localparam int CNT_MAX = (COIN_HOLD > COIN_GAP) ? COIN_HOLD : COIN_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(COIN_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(COIN_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP_S = 2'd2
  } coin_state_t;

  // DIP lives encoding as the cabinet expects it
  function automatic logic [2:0] dip_lives(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'b011;
      2'd1:    return 3'b110;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // One-hot pick with up > down > left > right; vector is {up, down, left, right}
  function automatic logic [3:0] pick_dir(input logic [3:0] v);
    if (v[3])      return 4'b1000;
    else if (v[2]) return 4'b0100;
    else if (v[1]) return 4'b0010;
    else if (v[0]) return 4'b0001;
    else           return 4'b0000;
  endfunction

  // Newest press wins; otherwise keep the active direction while it is held
  function automatic logic [3:0] arb_dir(input logic [3:0] d, input logic [3:0] p,
                                         input logic [3:0] act);
    logic [3:0] fresh;
    fresh = d & ~p;
    if (fresh != 4'b0000)     return pick_dir(fresh);
    else if ((act & d) != 4'b0000) return act;
    else                      return pick_dir(d);
  endfunction

  logic [7:0]       dip0_q = 8'h00;
  logic [4:0]       joy0_s1_q, joy1_s1_q;
  logic             coin_prev_q;
  logic [3:0]       p1_prev_q, p2_prev_q;
  logic [3:0]       p1_act_q, p2_act_q, p1_act_d, p2_act_d;
  coin_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       in1_q, in1_d;
  logic             coin_busy_q, coin_busy_d;
  logic             coin_any, coin_edge;
  logic             unused_joy;

  assign unused_joy = ^{joystick_0[15:5], joystick_1[15:5]};

  // DIP latch keeps its contents across resets so OSD/ROM resets preserve settings
  always_ff @(posedge clk) begin
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr == 25'd0)
      dip0_q <= ioctl_dout;
  end

  // Stage S1: raw joystick sample, plus previous-sample history for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy0_s1_q   <= 5'd0;
      joy1_s1_q   <= 5'd0;
      coin_prev_q <= 1'b0;
      p1_prev_q   <= 4'd0;
      p2_prev_q   <= 4'd0;
    end else begin
      joy0_s1_q   <= joystick_0[4:0];
      joy1_s1_q   <= joystick_1[4:0];
      coin_prev_q <= coin_any;
      p1_prev_q   <= joy0_s1_q[3:0];
      p2_prev_q   <= joy1_s1_q[3:0];
    end
  end

  assign coin_any  = joy0_s1_q[4] | joy1_s1_q[4];
  assign coin_edge = coin_any & ~coin_prev_q;

  // Coin FSM next state; edges outside IDLE are dropped, not queued
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      COIN_IDLE: begin
        if (coin_edge) begin
          state_d = COIN_PULSE;
          cnt_d   = HOLD_LOAD;
        end
      end
      COIN_PULSE: begin
        if (cnt_q == '0) begin
          state_d = COIN_GAP_S;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      COIN_GAP_S: begin
        if (cnt_q == '0) state_d = COIN_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      default: begin
        state_d = COIN_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output byte assembly from the next FSM state and S1-derived arbitration
  always_comb begin
    in1_d       = ~{(state_d == COIN_PULSE), dip_lives(dip0_q[1:0]), 4'b0000};
    coin_busy_d = (state_d != COIN_IDLE);
    p1_act_d    = arb_dir(joy0_s1_q[3:0], p1_prev_q, p1_act_q);
    p2_act_d    = arb_dir(joy1_s1_q[3:0], p2_prev_q, p2_act_q);
  end

  // Stage S2: registered FSM state and core-facing outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COIN_IDLE;
      cnt_q       <= '0;
      in1_q       <= 8'hFF;
      coin_busy_q <= 1'b0;
      p1_act_q    <= 4'd0;
      p2_act_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in1_q       <= in1_d;
      coin_busy_q <= coin_busy_d;
      p1_act_q    <= p1_act_d;
      p2_act_q    <= p2_act_d;
    end
  end

  assign in0       = 8'hFF;
  assign in1       = in1_q;
  assign in2       = ~{p2_act_q[1], p2_act_q[2], p2_act_q[0], p2_act_q[3],
                       p1_act_q[1], p1_act_q[2], p1_act_q[0], p1_act_q[3]};
  assign coin_busy = coin_busy_q;

endmodule

// File: tb/tb_blockade_input_cond.sv
// Directed bench for blockade_input_cond with a short coin hold/gap.
module tb_blockade_input_cond;

  logic        clk;
  logic        reset;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic [7:0]  in0, in1, in2;
  logic        coin_busy;

  int checks = 0;
  int errors = 0;
  int lows;

  blockade_input_cond #(.COIN_HOLD(4), .COIN_GAP(3)) dut (
    .clk(clk), .reset(reset), .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .joystick_0(joystick_0),
    .joystick_1(joystick_1), .in0(in0), .in1(in1), .in2(in2), .coin_busy(coin_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic dip_wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr    = 1'b1;
    ioctl_index = idx;
    ioctl_addr  = addr;
    ioctl_dout  = data;
    tick(1);
    ioctl_wr    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ioctl_wr = 1'b0; ioctl_index = 8'd0; ioctl_addr = 25'd0;
    ioctl_dout = 8'd0; joystick_0 = 16'd0; joystick_1 = 16'd0;
    tick(2);
    chk("rst_in0", in0, 8'hFF);
    chk("rst_in1", in1, 8'hFF);
    chk("rst_in2", in2, 8'hFF);
    chk("rst_busy", {7'd0, coin_busy}, 8'h00);
    reset = 1'b0;
    tick(1);
    chk("post_rst_in1", in1, 8'hCF);
    chk("post_rst_in2", in2, 8'hFF);

    // everything pressed, then async reset mid-pulse
    joystick_0 = 16'h001F; joystick_1 = 16'h001F;
    tick(2);
    chk("all_in2", in2, 8'hEE);
    chk("all_in1", in1, 8'h4F);
    chk("all_busy", {7'd0, coin_busy}, 8'h01);
    @(posedge clk); #2 reset = 1'b1; #1;
    chk("async_in0", in0, 8'hFF);
    chk("async_in1", in1, 8'hFF);
    chk("async_in2", in2, 8'hFF);
    chk("async_busy", {7'd0, coin_busy}, 8'h00);
    joystick_0 = 16'd0; joystick_1 = 16'd0;
    @(negedge clk); reset = 1'b0;
    tick(1);
    chk("rel_in1", in1, 8'hCF);
    chk("rel_in2", in2, 8'hFF);
    chk("rel_busy", {7'd0, coin_busy}, 8'h00);

    // DIP latch
    dip_wr(8'd254, 25'd0, 8'h01); tick(1);
    chk("dip1", in1, 8'h9F);
    dip_wr(8'd254, 25'd1, 8'h02); tick(1);
    chk("dip_addr1_ignored", in1, 8'h9F);
    dip_wr(8'd253, 25'd0, 8'h03); tick(1);
    chk("dip_idx_ignored", in1, 8'h9F);
    dip_wr(8'd254, 25'd0, 8'h02); tick(1);
    chk("dip2", in1, 8'hBF);
    dip_wr(8'd254, 25'd0, 8'h03); tick(1);
    chk("dip3", in1, 8'hFF);
    dip_wr(8'd254, 25'd0, 8'h01); tick(1);
    chk("dip1_again", in1, 8'h9F);
    @(posedge clk); #2 reset = 1'b1; #1;
    chk("dip_rst_in1", in1, 8'hFF);
    tick(2); reset = 1'b0;
    tick(1);
    chk("dip_kept", in1, 8'h9F);

    // 1-clk coin press, second press in GAP, third press right after IDLE
    joystick_0 = 16'h0010;
    for (int k = 1; k <= 18; k++) begin
      logic ec, eb;
      tick(1);
      ec = ((k >= 2) && (k <= 5)) || ((k >= 11) && (k <= 14));
      eb = ((k >= 2) && (k <= 8)) || ((k >= 11) && (k <= 17));
      chk($sformatf("coin_n%0d", k), {7'd0, ~in1[7]}, {7'd0, ec});
      chk($sformatf("busy_n%0d", k), {7'd0, coin_busy}, {7'd0, eb});
      if (k == 2) chk("coin_in1_byte", in1, 8'h1F);
      if (k == 6 || k == 9) joystick_0 = 16'h0010;
      else                  joystick_0 = 16'h0000;
    end

    // coin held 20 clk: one pulse only; release and re-press: another pulse
    joystick_1 = 16'h0010;
    lows = 0;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      if (in1[7] == 1'b0) lows++;
      if (k == 20) joystick_1 = 16'h0000;
    end
    chk("held_coin_lows", 8'(lows), 8'd4);
    joystick_1 = 16'h0010;
    lows = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (in1[7] == 1'b0) lows++;
      if (k == 2) joystick_1 = 16'h0000;
    end
    chk("repress_lows", 8'(lows), 8'd4);

    // P1 right, then add left, release left, release all
    joystick_0 = 16'h0001; tick(2);
    chk("p1_right", in2, 8'hFD);
    tick(3); joystick_0 = 16'h0003;
    tick(1);
    chk("p1_right_lat", in2, 8'hFD);
    tick(1);
    chk("p1_left_new", in2, 8'hF7);
    joystick_0 = 16'h0001; tick(2);
    chk("p1_back_right", in2, 8'hFD);
    joystick_0 = 16'h0000; tick(2);
    chk("p1_released", in2, 8'hFF);

    // simultaneous up+right on P1 with P2 down, then P2 adds up
    joystick_0 = 16'h0009; joystick_1 = 16'h0004; tick(2);
    chk("p1_up_p2_down", in2, 8'hBE);
    joystick_1 = 16'h000C; tick(2);
    chk("p2_up_new", in2, 8'hEE);
    joystick_0 = 16'h0000; joystick_1 = 16'h0000; tick(2);
    chk("both_released", in2, 8'hFF);

    // left then right pressed later: right is held despite left priority
    joystick_0 = 16'h0002; tick(2);
    chk("p1_left", in2, 8'hF7);
    joystick_0 = 16'h0003; tick(2);
    chk("p1_right_new", in2, 8'hFD);
    tick(3);
    chk("p1_right_held", in2, 8'hFD);
    joystick_0 = 16'h0000; tick(2);
    chk("final_in2", in2, 8'hFF);
    chk("final_in0", in0, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
